// File: rtl/rot_req_buffer.sv
// rot_req_buffer: request buffer in front of an external combinational rotator.
// Incoming {data, amt, op} requests wait in a 2-entry in-order queue. The queue head
// is presented to the rotator on rot_in_/rot_amt/rot_op. The rotator result comes back
// on rot_out and is captured into a result register that drives out_val/out_data.
// Optional feature: define ROT_REQ_BYPASS_EN to let a request go straight into the
// result register when the queue is empty. This cuts latency by one cycle.
// Without that macro there is no bypass path.
module rot_req_buffer #(
    parameter int nbits = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_val,
    output logic                     in_rdy,
    input  logic [nbits-1:0]         in_data,
    input  logic [$clog2(nbits)-1:0] in_amt,
    input  logic                     in_op,
    output logic [nbits-1:0]         rot_in_,
    output logic [$clog2(nbits)-1:0] rot_amt,
    output logic                     rot_op,
    input  logic [nbits-1:0]         rot_out,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [nbits-1:0]         out_data
);

    localparam int aw = $clog2(nbits);

    // Queue storage and bookkeeping
    logic [nbits-1:0] q_data_reg [2];
    logic [aw-1:0]    q_amt_reg  [2];
    logic             q_op_reg   [2];
    logic [1:0]       count_reg;
    logic [1:0]       count_next;
    logic             head_reg;
    logic             head_next;

    // Result register
    logic             rval_reg;
    logic [nbits-1:0] rdata_reg;

    // Handshake / control terms
    logic q_empty;
    logic r_free;
    logic accept;
    logic bypass_take;
    logic enq;
    logic deq;
    logic wr_ptr;

    assign q_empty = (count_reg == 2'd0);
    // The result register can take a new value when it is empty or is being drained this cycle.
    assign r_free  = !rval_reg || out_rdy;
    // in_rdy depends only on occupancy and reset. A full queue never accepts input,
    // even in a cycle where the head leaves the queue.
    assign in_rdy  = !reset && (count_reg != 2'd2);
    assign accept  = in_val && in_rdy;

`ifdef ROT_REQ_BYPASS_EN
    // An empty queue lets an accepted request skip the queue and go into R directly.
    assign bypass_take = q_empty && accept && r_free;
`else
    assign bypass_take = 1'b0;
`endif

    assign enq    = accept && !bypass_take;
    assign deq    = !q_empty && r_free;
    // The write slot is the slot just past the newest entry.
    // When the queue is empty, that is the head slot.
    assign wr_ptr = head_reg ^ count_reg[0];

    // Next occupancy and head pointer. A simultaneous enqueue and dequeue leaves count unchanged.
    always_comb begin
        count_next = count_reg;
        head_next  = head_reg;
        if (enq && !deq) begin
            count_next = count_reg + 2'd1;
        end else if (!enq && deq) begin
            count_next = count_reg - 2'd1;
        end
        if (deq) begin
            head_next = ~head_reg;
        end
    end

    // Occupancy and head pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= 2'd0;
            head_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            head_reg  <= head_next;
        end
    end

    // Per-slot storage. A slot is written only when it is the current write slot.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            logic slot_we;
            assign slot_we = enq && (wr_ptr == 1'(gi));

            // Capture an accepted request into this slot
            always_ff @(posedge clk) begin
                if (reset) begin
                    q_data_reg[gi] <= '0;
                    q_amt_reg[gi]  <= '0;
                    q_op_reg[gi]   <= 1'b0;
                end else if (slot_we) begin
                    q_data_reg[gi] <= in_data;
                    q_amt_reg[gi]  <= in_amt;
                    q_op_reg[gi]   <= in_op;
                end
            end
        end
    endgenerate

    // Rotator operands: the queue head, the bypassed input, or zeros when idle
    always_comb begin
        rot_in_ = '0;
        rot_amt = '0;
        rot_op  = 1'b0;
        if (!q_empty) begin
            rot_in_ = q_data_reg[head_reg];
            rot_amt = q_amt_reg[head_reg];
            rot_op  = q_op_reg[head_reg];
        end
`ifdef ROT_REQ_BYPASS_EN
        else if (in_val) begin
            rot_in_ = in_data;
            rot_amt = in_amt;
            rot_op  = in_op;
        end
`endif
    end

    // Result register: load the rotator output on a head move or bypass.
    // Drop the result on a handshake when nothing new arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            rval_reg  <= 1'b0;
            rdata_reg <= '0;
        end else if (deq || bypass_take) begin
            rval_reg  <= 1'b1;
            rdata_reg <= rot_out;
        end else if (out_rdy) begin
            rval_reg  <= 1'b0;
        end
    end

    assign out_val  = rval_reg && !reset;
    assign out_data = rdata_reg;

endmodule

// File: tb/tb_rot_req_buffer.sv
// Testbench for rot_req_buffer (nbits = 8).
// Expected results go into a scoreboard queue when a request is accepted.
// A negedge monitor pops the queue and compares on every output handshake.
// The external rotator is modelled here as a combinational block.
module tb_rot_req_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_val;
    logic       in_rdy;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       in_op;
    logic [7:0] rot_in_;
    logic [2:0] rot_amt;
    logic       rot_op;
    logic [7:0] rot_out;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out_data;

`ifdef ROT_REQ_BYPASS_EN
    localparam int lat_extra = 0;
`else
    localparam int lat_extra = 1;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q [$];

    rot_req_buffer #(.nbits(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_data (in_data),
        .in_amt  (in_amt),
        .in_op   (in_op),
        .rot_in_ (rot_in_),
        .rot_amt (rot_amt),
        .rot_op  (rot_op),
        .rot_out (rot_out),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_data(out_data)
    );

    always #5 clk = ~clk;

    // External combinational rotator (doubled-word shift)
    logic [15:0] dbl_l, dbl_r;
    always_comb begin
        dbl_l   = {rot_in_, rot_in_} << rot_amt;
        dbl_r   = {rot_in_, rot_in_} >> rot_amt;
        rot_out = rot_op ? dbl_r[7:0] : dbl_l[15:8];
    end

    // Golden rotate, computed bit by bit
    function automatic logic [7:0] golden(input logic [7:0] x, input logic [2:0] a, input logic op);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            if (op) r[i] = x[(i + int'(a)) % 8];
            else    r[(i + int'(a)) % 8] = x[i];
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compares results on each output handshake and checks that held data stays stable
    initial begin
        logic       prev_hold;
        logic       prev_reset;
        logic [7:0] prev_data;
        logic [7:0] e;
        prev_hold  = 1'b0;
        prev_reset = 1'b1;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (prev_hold && !reset && !prev_reset) begin
                check("hold_valid", int'(out_val), 1);
                check("hold_data", int'(out_data), int'(prev_data));
            end
            if (out_val && out_rdy) begin
                if (exp_q.size() == 0) begin
                    check("stale_result", int'(out_val), 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("out txn: data=0x%02h expected=0x%02h", out_data, e);
                    check("result_data", int'(out_data), int'(e));
                end
            end
            prev_hold  = out_val && !out_rdy;
            prev_data  = out_data;
            prev_reset = reset;
        end
    end

    // Issue one request starting at posedge+1. The task returns at a later posedge+1.
    task automatic send(input logic [7:0] d, input logic [2:0] a, input logic op,
                        input logic [7:0] e, input bit chk_lat);
        int w;
        int n;
        w = 0;
        in_val = 1'b1; in_data = d; in_amt = a; in_op = op;
        @(negedge clk);
        while (!in_rdy && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_rdy) check("in_rdy_timeout", int'(in_rdy), 1);
        else begin
            exp_q.push_back(e);
            $display("in txn: data=0x%02h amt=%0d op=%0d", d, a, op);
        end
        @(posedge clk); #1;
        in_val = 1'b0;
        if (chk_lat) begin
            n = 0;
            @(negedge clk);
            while (!out_val && n < 10) begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end
            check("latency", n, lat_extra);
            @(posedge clk); #1;
        end
    endtask

    // Drain: wait (bounded) until every expected result has been seen
    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        check("drain_remaining", exp_q.size(), 0);
    endtask

    // Present four requests back to back. Return how many the DUT accepted.
    task automatic burst4(input logic [7:0] d [4], input logic [2:0] a [4],
                          input logic op [4], input bit push);
        for (int k = 0; k < 4; k++) begin
            in_val = 1'b1; in_data = d[k]; in_amt = a[k]; in_op = op[k];
            @(negedge clk);
            check($sformatf("burst_in_rdy_%0d", k), int'(in_rdy), (k < 3) ? 1 : 0);
            if (in_rdy && push) exp_q.push_back(golden(d[k], a[k], op[k]));
            @(posedge clk); #1;
        end
        in_val = 1'b0;
    endtask

    logic [7:0] bd [4];
    logic [2:0] ba [4];
    logic       bo [4];
    bit         rand_done;

    initial begin
        reset = 1'b1; in_val = 1'b0; in_data = '0; in_amt = '0; in_op = 1'b0; out_rdy = 1'b1;
        // Reset behaviour
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_rdy", int'(in_rdy), 0);
        check("reset_out_val", int'(out_val), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_in_rdy", int'(in_rdy), 1);
        check("post_reset_out_val", int'(out_val), 0);
        check("post_reset_out_data", int'(out_data), 0);
        check("post_reset_rot_in", int'(rot_in_), 0);
        check("post_reset_rot_amt", int'(rot_amt), 0);
        check("post_reset_rot_op", int'(rot_op), 0);
        @(posedge clk); #1;

        // Directed single requests with latency checks
        send(8'h81, 3'd1, 1'b0, 8'h03, 1'b1);
        send(8'h01, 3'd1, 1'b1, 8'h80, 1'b1);
        send(8'hA5, 3'd0, 1'b0, 8'hA5, 1'b1);
        send(8'hF0, 3'd4, 1'b0, 8'h0F, 1'b1);
        drain();

        // Backpressure: three accepted, the fourth refused
        out_rdy = 1'b0;
        bd = '{8'h12, 8'h80, 8'h3C, 8'hFF};
        ba = '{3'd4, 3'd7, 3'd2, 3'd1};
        bo = '{1'b0, 1'b0, 1'b1, 1'b0};
        burst4(bd, ba, bo, 1'b1);
        check("bp_expected_count", exp_q.size(), 3);
        check("bp_head_expect", int'(exp_q[0]), 8'h21);
        repeat (2) begin @(posedge clk); #1; end
        out_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp_release_val_%0d", k), int'(out_val), 1);
        end
        @(negedge clk);
        check("bp_release_idle", int'(out_val), 0);
        @(posedge clk); #1;
        drain();

        // Reset while the queue is full and R holds a result
        out_rdy = 1'b0;
        burst4(bd, ba, bo, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_in_rdy", int'(in_rdy), 0);
        check("midreset_out_val", int'(out_val), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("after_midreset_in_rdy", int'(in_rdy), 1);
        check("after_midreset_out_val", int'(out_val), 0);
        check("after_midreset_out_data", int'(out_data), 0);
        out_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("no_stale_%0d", k), int'(out_val), 0);
        end
        @(posedge clk); #1;

        // Random stream while out_rdy toggles
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 16; k++) begin
                    logic [7:0] d;
                    logic [2:0] a;
                    logic       op;
                    d  = 8'($urandom);
                    a  = 3'($urandom_range(0, 7));
                    op = 1'($urandom_range(0, 1));
                    send(d, a, op, golden(d, a, op), 1'b0);
                    repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_rdy = ~out_rdy;
                end
            end
        join
        out_rdy = 1'b1;
        drain();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
